// File: rtl/pcmodule.sv
// pcmodule: program counter with next/stack/branch/jump sources; optional pc_hold port when PC_HOLD_EN is defined
module pcmodule #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
`ifdef PC_HOLD_EN
   input  logic        pc_hold,
`endif
   input  logic [31:0] I_TypeImmediate,
   input  logic [31:0] J_TypeImmediate,
   input  logic [31:0] topstack,
   input  logic [1:0]  sig_pc_src,
   output logic [31:0] PC,
   output logic [31:0] pc_plus_1
);
   logic [31:0] pc_q = RESET_VECTOR;
   logic [31:0] pc_d;
   logic [31:0] pc_sel;
   logic        hold;
`ifdef PC_HOLD_EN
   assign hold = pc_hold;
`else
   assign hold = 1'b0;
`endif
   assign PC        = pc_q;
   assign pc_plus_1 = pc_q + 32'd1;
   // case with default so an unknown select falls back to sequential fetch
   always_comb begin
      pc_sel = pc_plus_1;
      case (sig_pc_src)
         2'b01:   pc_sel = topstack;
         2'b10:   pc_sel = pc_q + I_TypeImmediate;
         2'b11:   pc_sel = {pc_q[31:26], J_TypeImmediate[25:0]};
         default: pc_sel = pc_plus_1;
      endcase
      pc_d = reset ? RESET_VECTOR : hold ? pc_q : pc_sel;
   end
   always_ff @(posedge clock) pc_q <= pc_d;
endmodule

// File: tb/tb_pcmodule.sv
// tb_pcmodule: directed checks of pcmodule source selection, wrap, reset and optional hold
module tb_pcmodule;
   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        pc_hold = 1'b0;
   logic [31:0] I_TypeImmediate = '0;
   logic [31:0] J_TypeImmediate = '0;
   logic [31:0] topstack = '0;
   logic [1:0]  sig_pc_src = 2'b00;
   logic [31:0] PC;
   logic [31:0] pc_plus_1;
   int total = 0;
   int bad = 0;

   pcmodule dut (
      .clock(clock),
      .reset(reset),
`ifdef PC_HOLD_EN
      .pc_hold(pc_hold),
`endif
      .I_TypeImmediate(I_TypeImmediate),
      .J_TypeImmediate(J_TypeImmediate),
      .topstack(topstack),
      .sig_pc_src(sig_pc_src),
      .PC(PC),
      .pc_plus_1(pc_plus_1)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step(input logic [1:0] src, input logic [31:0] ts, input logic [31:0] ii, input logic [31:0] jj);
      sig_pc_src = src;
      topstack = ts;
      I_TypeImmediate = ii;
      J_TypeImmediate = jj;
      @(posedge clock);
      #1;
   endtask

   initial begin
      #1;
      chk("init_pc", PC, 32'h0);
      chk("init_plus1", pc_plus_1, 32'h1);
      reset = 1'b1;
      step(2'b11, 0, 0, 32'h0000_1234);
      chk("reset_pc", PC, 32'h0);
      reset = 1'b0;
      step(2'b00, 0, 0, 0); chk("next_1", PC, 32'h1);
      step(2'b00, 0, 0, 0); chk("next_2", PC, 32'h2);
      step(2'b00, 0, 0, 0); chk("next_3", PC, 32'h3);
      step(2'b01, 32'd5, 0, 0); chk("stack_5", PC, 32'h5);
      step(2'b10, 0, 32'hFFFF_FFFD, 0); chk("bta_neg", PC, 32'h2);
      step(2'b01, 32'd5, 0, 0);
      step(2'b10, 0, 32'd8, 0); chk("bta_pos", PC, 32'd13);
      step(2'b01, 32'hFC00_0010, 0, 0);
      step(2'b11, 0, 0, 32'h0000_1234); chk("ja_keep_hi", PC, 32'hFC00_1234);
      step(2'b01, 32'h0000_0010, 0, 0);
      step(2'b11, 0, 0, 32'hFFFF_5678); chk("ja_mask", PC, 32'h03FF_5678);
      step(2'b01, 32'h0000_0ABC, 0, 0);
      chk("stack_abc", PC, 32'h0000_0ABC);
      chk("plus1_abd", pc_plus_1, 32'h0000_0ABD);
      step(2'b01, 32'hFFFF_FFFF, 0, 0);
      chk("plus1_wrap", pc_plus_1, 32'h0);
      step(2'b00, 0, 0, 0); chk("next_wrap", PC, 32'h0);
      step(2'b01, 32'h0000_0100, 0, 0);
      reset = 1'b1;
      step(2'b10, 0, 32'd8, 0); chk("reset_over_bta", PC, 32'h0);
      reset = 1'b0;
      step(2'b10, 0, 32'd8, 0); chk("post_reset_bta", PC, 32'h8);
      step(2'bxx, 32'h55, 32'h77, 32'h99); chk("x_src_next", PC, 32'h9);
`ifdef PC_HOLD_EN
      step(2'b01, 32'd7, 0, 0);
      pc_hold = 1'b1;
      step(2'b00, 0, 0, 0); chk("hold_7", PC, 32'h7);
      pc_hold = 1'b0;
      step(2'b00, 0, 0, 0); chk("unhold_8", PC, 32'h8);
      pc_hold = 1'b1;
      reset = 1'b1;
      step(2'b00, 0, 0, 0); chk("reset_over_hold", PC, 32'h0);
      reset = 1'b0;
      pc_hold = 1'b0;
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
